keccak_state_unpacker: RTL and testbench
========================================

Name: keccak_state_unpacker

Overview:
- Consumer side of the halfword-shuffled Keccak state path.
- Accepts one 1600-bit Keccak state with its 16-bit halfwords reversed inside each 64-bit lane, then restores the natural halfword order.
- Streams the restored state out as 25 sequential 64-bit lanes over a valid/ready interface.
- Sits between the Keccak permutation output and the lane-wide consumers: scratchpad init, AES key expansion, final hash select.

Parameters:
- LANE_W, 64, lane width in bits; fixed, must be a multiple of HW_W.
- HW_W, 16, swap granularity in bits.
- NUM_LANES, 25, lanes per state; input width = LANE_W*NUM_LANES = 1600.

Ports:
- i_clk  input  1  single clock, all logic on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  input state valid.
- o_ready  output  1  unpacker can accept a state this cycle.
- i_v_data  input  1600  shuffled state; lane k is bits [64k+63:64k].
- o_valid  output  1  output lane valid.
- i_ready  input  1  downstream accepts the lane.
- o_v_data  output  64  unshuffled lane.
- o_lane_idx  output  5  index of the current lane, 0..24.
- o_last  output  1  high with lane 24.

Behaviour:
- Reset is synchronous, sampled on i_clk while i_rst_n=0. Reset values:
  - o_valid=0, o_v_data=0, o_lane_idx=0, o_last=0.
  - State=IDLE, state buffer contents don't-care.
  - o_ready=0 while i_rst_n=0; o_ready=1 on the first cycle after reset release.
- Unshuffle per lane, with L = input lane:
  - out[63:48] = L[15:0]
  - out[47:32] = L[31:16]
  - out[31:16] = L[47:32]
  - out[15:0] = L[63:48]
  - The mapping is an involution. Apply it either at capture or at output; the visible result is identical.
- FSM states: IDLE, STREAM.
  - IDLE: o_ready=1, o_valid=0. On i_valid & o_ready:
    - capture i_v_data into a 1600-bit buffer;
    - go to STREAM with lane counter 0;
    - o_valid rises the next cycle (capture-to-first-lane latency 1 cycle).
  - STREAM: o_valid=1; o_v_data = unshuffled lane[cnt]; o_lane_idx = cnt; o_last = (cnt==24).
    - On i_ready & o_valid with cnt<24: cnt increments and the next lane is presented the following cycle.
    - With i_ready=0: o_v_data, o_lane_idx and o_last hold stable; AXI-style, no retraction.
- Last-lane overlap for back-to-back states, with no bubble:
  - In STREAM with cnt==24, o_ready = i_ready.
  - If lane 24 is accepted and i_valid=1 in the same cycle: the new state is captured, cnt resets to 0, state stays STREAM, and lane 0 of the new state is valid the next cycle.
  - If lane 24 is accepted and i_valid=0: return to IDLE, o_valid=0 the next cycle.
- Throughput is 1 lane/cycle under continuous i_ready, i.e. 25 cycles per state.
- o_ready=0 in STREAM whenever cnt<24; i_valid is ignored in those cycles. The upstream must hold i_v_data until handshake.
- Reset mid-stream:
  - discards the remaining lanes;
  - o_valid=0 the cycle after reset is sampled;
  - no partial state is replayed.
- Counter width is 5 bits. It never exceeds 24; values 25..31 are unreachable and must be covered by an assertion.
- Outputs are registered from the buffer and counter. The o_v_data mux is from a registered buffer, so there is no combinational path i_v_data -> o_v_data.
- o_ready is combinational from state, cnt and i_ready. This is the only comb path, i_ready -> o_ready, and it is documented for integrators.

Decomposition:
- Shared package keccak_pkg:
  - KECCAK_LANE_W=64, KECCAK_NUM_LANES=25, KECCAK_STATE_W=1600, KECCAK_HW_W=16;
  - lane index width (5);
  - FSM state enum {IDLE, STREAM}.
- One natural sub-module, keccak_lane_unswap: combinational 64-bit halfword reversal, instantiated once on the selected lane. It is reusable by the packer side.

Test Plan:
- Single state, i_ready=1, lane0 = 64'h0123_4567_89AB_CDEF:
  - lane 0 output 64'hCDEF_89AB_4567_0123 one cycle after the handshake;
  - all 25 lanes follow on consecutive cycles with idx 0..24;
  - o_last only on idx 24;
  - then o_valid=0 and o_ready=1.
- Back-to-back states A then B, i_valid held high, i_ready=1: 50 consecutive valid lanes with no bubble; B's capture coincides with A's lane-24 handshake; o_ready=0 during A's lanes 0..23.
- Backpressure with random i_ready (about 50%):
  - o_v_data and o_lane_idx stable while o_valid & !i_ready;
  - the sequence matches a reference model (lane k = halfword-reversed input lane k);
  - no lane dropped or duplicated.
- i_valid asserted during STREAM with cnt=10: not captured, o_ready=0; the state is accepted only at the lane-24 handshake.
- Reset asserted at cnt=12 for 1 cycle:
  - o_valid=0 the next cycle, o_lane_idx=0;
  - o_ready=1 after release;
  - a new state C streams correctly from lane 0.
- Involution check: input lane 64'hFFFF_0000_AAAA_5555 -> output 64'h5555_AAAA_0000_FFFF. An all-zero state yields 25 zero lanes.

Source files
------------

// File: rtl/keccak_pkg.sv
// keccak_pkg
// Shared constants and types for the Keccak state path: lane/state geometry,
// lane index width and the unpacker FSM state encoding.
package keccak_pkg;

    localparam int KECCAK_LANE_W    = 64;
    localparam int KECCAK_NUM_LANES = 25;
    localparam int KECCAK_STATE_W   = KECCAK_LANE_W * KECCAK_NUM_LANES;
    localparam int KECCAK_HW_W      = 16;
    localparam int KECCAK_IDX_W     = 5;

    localparam logic [KECCAK_IDX_W-1:0] KECCAK_LAST_IDX = KECCAK_IDX_W'(KECCAK_NUM_LANES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } unpack_state_e;

endpackage

// File: rtl/keccak_state_unpacker_if.sv
// keccak_state_unpacker_if
// Bundles both handshakes of the state unpacker.
//   Input side : i_valid, o_ready, i_v_data (1600-bit halfword-shuffled state)
//   Output side: o_valid, i_ready, o_v_data (64-bit lane), o_lane_idx, o_last
// Modports:
//   slave  - the unpacker itself
//   master - the surrounding logic (upstream producer + downstream consumer)
// Integrator note: o_ready depends combinationally on i_ready while the last
// lane of a state is being presented.
interface keccak_state_unpacker_if;
    import keccak_pkg::*;

    logic                        i_valid;
    logic                        o_ready;
    logic [KECCAK_STATE_W-1:0]   i_v_data;
    logic                        o_valid;
    logic                        i_ready;
    logic [KECCAK_LANE_W-1:0]    o_v_data;
    logic [KECCAK_IDX_W-1:0]     o_lane_idx;
    logic                        o_last;

    modport slave (
        input  i_valid, i_v_data, i_ready,
        output o_ready, o_valid, o_v_data, o_lane_idx, o_last
    );

    modport master (
        output i_valid, i_v_data, i_ready,
        input  o_ready, o_valid, o_v_data, o_lane_idx, o_last
    );

endinterface

// File: rtl/keccak_lane_unswap.sv
// keccak_lane_unswap
// Purely combinational halfword reversal inside one lane. The mapping is its
// own inverse, so the packer side can reuse this block unchanged.
// Ports:
//   lane_in  - lane with halfwords in shuffled order
//   lane_out - lane with halfword i moved to position (N-1-i)
module keccak_lane_unswap #(
    parameter int LANE_W = 64,
    parameter int HW_W   = 16
) (
    input  logic [LANE_W-1:0] lane_in,
    output logic [LANE_W-1:0] lane_out
);

    localparam int NUM_HW = LANE_W / HW_W;

    for (genvar i = 0; i < NUM_HW; i++) begin : g_hw
        assign lane_out[i*HW_W +: HW_W] = lane_in[(NUM_HW-1-i)*HW_W +: HW_W];
    end

endmodule

// File: rtl/keccak_state_unpacker.sv
// keccak_state_unpacker
// Captures one halfword-shuffled 1600-bit Keccak state and streams it out as
// 25 lanes of 64 bits with the natural halfword order restored.
// Ports:
//   i_clk   - clock, everything on the rising edge
//   i_rst_n - synchronous active-low reset
//   bus     - slave side of keccak_state_unpacker_if (state in, lanes out)
// The only combinational path is i_ready -> o_ready, active on the last lane
// so a following state can be captured without a bubble.
module keccak_state_unpacker
    import keccak_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    keccak_state_unpacker_if.slave   bus
);

    unpack_state_e                                      state_q, state_d;
    logic [KECCAK_IDX_W-1:0]                            cnt_q, cnt_d;
    logic                                               ready_en_q;
    logic                                               capture;
    logic                                               ready;
    logic [KECCAK_NUM_LANES-1:0][KECCAK_LANE_W-1:0]     buf_q;
    logic [KECCAK_LANE_W-1:0]                           sel_lane;
    logic [KECCAK_LANE_W-1:0]                           unswapped;

    // Control registers. ready_en_q keeps o_ready low through reset and lets
    // it rise only once a clock edge has seen reset released.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    // State buffer has no reset; its contents only matter once captured.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            buf_q <= bus.i_v_data;
        end
    end

    // Next-state logic. On the last lane the unpacker is ready exactly when
    // the downstream takes that lane, so a waiting state overlaps with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = ready_en_q;
                if (bus.i_valid && ready_en_q) begin
                    capture = 1'b1;
                    state_d = STREAM;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (cnt_q == KECCAK_LAST_IDX) begin
                    ready = bus.i_ready;
                    if (bus.i_ready) begin
                        cnt_d = '0;
                        if (bus.i_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (bus.i_ready) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign sel_lane = buf_q[cnt_q];

    keccak_lane_unswap #(
        .LANE_W (KECCAK_LANE_W),
        .HW_W   (KECCAK_HW_W)
    ) u_unswap (
        .lane_in  (sel_lane),
        .lane_out (unswapped)
    );

    // Lane data is forced to zero outside STREAM so the buffer's don't-care
    // contents never leak out after reset.
    assign bus.o_ready    = ready;
    assign bus.o_valid    = (state_q == STREAM);
    assign bus.o_v_data   = (state_q == STREAM) ? unswapped : '0;
    assign bus.o_lane_idx = cnt_q;
    assign bus.o_last     = (state_q == STREAM) && (cnt_q == KECCAK_LAST_IDX);

    cnt_in_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        cnt_q <= KECCAK_LAST_IDX);

endmodule

// File: tb/tb_keccak_state_unpacker.sv
// tb_keccak_state_unpacker
// Directed scenarios for the state unpacker, one task per scenario. Inputs
// are driven on the falling edge and outputs sampled 1 time unit later.
module tb_keccak_state_unpacker;
    import keccak_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    keccak_state_unpacker_if bus ();

    keccak_state_unpacker dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference halfword reversal written out field by field.
    function automatic logic [63:0] rev_hw(input logic [63:0] l);
        return {l[15:0], l[31:16], l[47:32], l[63:48]};
    endfunction

    function automatic logic [63:0] mk_lane(input int seed, input int k);
        logic [15:0] s;
        logic [15:0] n;
        s = 16'(seed * 311 + 257);
        n = 16'(k * 4099 + 17);
        return {s ^ n, n, s + n, ~s};
    endfunction

    function automatic logic [1599:0] mk_state(input int seed);
        logic [1599:0] st;
        for (int k = 0; k < 25; k++) st[64*k +: 64] = mk_lane(seed, k);
        return st;
    endfunction

    // Presents a state on the input side (handshake completes at the next rising edge).
    task automatic offer_state(input logic [1599:0] st);
        @(negedge clk);
        bus.i_v_data = st;
        bus.i_valid  = 1'b1;
        bus.i_ready  = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_ready  = 1'b0;
        bus.i_v_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_v_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_o_v_data: got %h expected 0", bus.o_v_data); end
        checks++; if (bus.o_lane_idx !== 5'd0) begin errors++; $display("[TB] FAIL reset_o_lane_idx: got %0d expected 0", bus.o_lane_idx); end
        checks++; if (bus.o_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_last: got %b expected 0", bus.o_last); end
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_ready_low: got %b expected 0", bus.o_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_o_ready_release: got %b expected 1", bus.o_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_valid: got %b expected 0", bus.o_valid); end
    endtask

    task automatic test_single_state();
        logic [1599:0] st;
        logic [63:0]   exp;
        st = mk_state(1);
        st[63:0]   = 64'h0123_4567_89AB_CDEF;
        st[127:64] = 64'hFFFF_0000_AAAA_5555;
        offer_state(st);
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_ready: got %b expected 1", bus.o_ready); end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            exp = rev_hw(st[64*k +: 64]);
            checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid lane %0d: got %b expected 1", k, bus.o_valid); end
            checks++; if (bus.o_v_data !== exp) begin errors++; $display("[TB] FAIL single_data lane %0d: got %h expected %h", k, bus.o_v_data, exp); end
            checks++; if (bus.o_lane_idx !== 5'(k)) begin errors++; $display("[TB] FAIL single_idx: got %0d expected %0d", bus.o_lane_idx, k); end
            checks++; if (bus.o_last !== (k == 24)) begin errors++; $display("[TB] FAIL single_last lane %0d: got %b expected %b", k, bus.o_last, (k == 24)); end
            checks++; if (bus.o_ready !== (k == 24)) begin errors++; $display("[TB] FAIL single_ready lane %0d: got %b expected %b", k, bus.o_ready, (k == 24)); end
            if (k == 0) begin
                checks++; if (bus.o_v_data !== 64'hCDEF_89AB_4567_0123) begin errors++; $display("[TB] FAIL single_lane0_const: got %h expected CDEF89AB45670123", bus.o_v_data); end
            end
            if (k == 1) begin
                checks++; if (bus.o_v_data !== 64'h5555_AAAA_0000_FFFF) begin errors++; $display("[TB] FAIL involution_const: got %h expected 5555AAAA0000FFFF", bus.o_v_data); end
            end
        end
        @(negedge clk);
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_end_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_end_ready: got %b expected 1", bus.o_ready); end
    endtask

    task automatic test_back_to_back();
        logic [1599:0] st_a;
        logic [1599:0] st_b;
        logic [63:0]   exp;
        int            k;
        st_a = mk_state(2);
        st_b = mk_state(3);
        offer_state(st_a);
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            bus.i_v_data = st_b;
            bus.i_valid  = (j < 25);
            #1;
            k   = j % 25;
            exp = (j < 25) ? rev_hw(st_a[64*k +: 64]) : rev_hw(st_b[64*k +: 64]);
            checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid beat %0d: got %b expected 1", j, bus.o_valid); end
            checks++; if (bus.o_v_data !== exp) begin errors++; $display("[TB] FAIL b2b_data beat %0d: got %h expected %h", j, bus.o_v_data, exp); end
            checks++; if (bus.o_lane_idx !== 5'(k)) begin errors++; $display("[TB] FAIL b2b_idx beat %0d: got %0d expected %0d", j, bus.o_lane_idx, k); end
            checks++; if (bus.o_ready !== (k == 24)) begin errors++; $display("[TB] FAIL b2b_ready beat %0d: got %b expected %b", j, bus.o_ready, (k == 24)); end
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_valid: got %b expected 0", bus.o_valid); end
    endtask

    task automatic test_backpressure();
        logic [1599:0] st;
        logic [63:0]   exp;
        int            exp_k;
        int            cyc;
        st    = mk_state(4);
        exp_k = 0;
        cyc   = 0;
        offer_state(st);
        while (exp_k < 25 && cyc < 400) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.i_ready = 1'($urandom_range(0, 1));
            #1;
            cyc++;
            exp = rev_hw(st[64*exp_k +: 64]);
            checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid cycle %0d: got %b expected 1", cyc, bus.o_valid); end
            checks++; if (bus.o_v_data !== exp) begin errors++; $display("[TB] FAIL bp_data cycle %0d: got %h expected %h", cyc, bus.o_v_data, exp); end
            checks++; if (bus.o_lane_idx !== 5'(exp_k)) begin errors++; $display("[TB] FAIL bp_idx cycle %0d: got %0d expected %0d", cyc, bus.o_lane_idx, exp_k); end
            checks++; if (bus.o_last !== (exp_k == 24)) begin errors++; $display("[TB] FAIL bp_last cycle %0d: got %b expected %b", cyc, bus.o_last, (exp_k == 24)); end
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) exp_k++;
        end
        checks++; if (exp_k != 25) begin errors++; $display("[TB] FAIL bp_timeout: got %0d lanes expected 25", exp_k); end
        @(negedge clk);
        bus.i_ready = 1'b1;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_end_valid: got %b expected 0", bus.o_valid); end
    endtask

    task automatic test_valid_during_stream();
        logic [1599:0] st_e;
        logic [1599:0] st_f;
        logic [63:0]   exp;
        st_e = mk_state(5);
        st_f = mk_state(6);
        offer_state(st_e);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            bus.i_valid  = (k >= 10);
            bus.i_v_data = (k >= 10) ? st_f : st_e;
            #1;
            exp = rev_hw(st_e[64*k +: 64]);
            checks++; if (bus.o_lane_idx !== 5'(k)) begin errors++; $display("[TB] FAIL vds_idx: got %0d expected %0d", bus.o_lane_idx, k); end
            checks++; if (bus.o_v_data !== exp) begin errors++; $display("[TB] FAIL vds_data lane %0d: got %h expected %h", k, bus.o_v_data, exp); end
            checks++; if (bus.o_ready !== (k == 24)) begin errors++; $display("[TB] FAIL vds_ready lane %0d: got %b expected %b", k, bus.o_ready, (k == 24)); end
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            exp = rev_hw(st_f[64*k +: 64]);
            checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL vds_f_valid lane %0d: got %b expected 1", k, bus.o_valid); end
            checks++; if (bus.o_lane_idx !== 5'(k)) begin errors++; $display("[TB] FAIL vds_f_idx: got %0d expected %0d", bus.o_lane_idx, k); end
            checks++; if (bus.o_v_data !== exp) begin errors++; $display("[TB] FAIL vds_f_data lane %0d: got %h expected %h", k, bus.o_v_data, exp); end
        end
        @(negedge clk);
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL vds_end_valid: got %b expected 0", bus.o_valid); end
    endtask

    task automatic test_reset_midstream();
        logic [1599:0] st_g;
        logic [1599:0] st_c;
        logic [63:0]   exp;
        st_g = mk_state(7);
        st_c = mk_state(8);
        offer_state(st_g);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            exp = rev_hw(st_g[64*k +: 64]);
            checks++; if (bus.o_lane_idx !== 5'(k)) begin errors++; $display("[TB] FAIL rst_mid_idx: got %0d expected %0d", bus.o_lane_idx, k); end
            checks++; if (bus.o_v_data !== exp) begin errors++; $display("[TB] FAIL rst_mid_data lane %0d: got %h expected %h", k, bus.o_v_data, exp); end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_lane_idx !== 5'd0) begin errors++; $display("[TB] FAIL rst_mid_idx_clear: got %0d expected 0", bus.o_lane_idx); end
        checks++; if (bus.o_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_last: got %b expected 0", bus.o_last); end
        offer_state(st_c);
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready_after: got %b expected 1", bus.o_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_idle_valid: got %b expected 0", bus.o_valid); end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            exp = rev_hw(st_c[64*k +: 64]);
            checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_c_valid lane %0d: got %b expected 1", k, bus.o_valid); end
            checks++; if (bus.o_lane_idx !== 5'(k)) begin errors++; $display("[TB] FAIL rst_c_idx: got %0d expected %0d", bus.o_lane_idx, k); end
            checks++; if (bus.o_v_data !== exp) begin errors++; $display("[TB] FAIL rst_c_data lane %0d: got %h expected %h", k, bus.o_v_data, exp); end
        end
        @(negedge clk);
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_c_end_valid: got %b expected 0", bus.o_valid); end
    endtask

    task automatic test_all_zero();
        offer_state('0);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            #1;
            checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_valid lane %0d: got %b expected 1", k, bus.o_valid); end
            checks++; if (bus.o_v_data !== 64'h0) begin errors++; $display("[TB] FAIL zero_data lane %0d: got %h expected 0", k, bus.o_v_data); end
            checks++; if (bus.o_lane_idx !== 5'(k)) begin errors++; $display("[TB] FAIL zero_idx: got %0d expected %0d", bus.o_lane_idx, k); end
        end
        @(negedge clk);
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_end_valid: got %b expected 0", bus.o_valid); end
    endtask

    initial begin
        $display("[TB] starting keccak_state_unpacker scenarios");
        test_reset();
        test_single_state();
        test_back_to_back();
        test_backpressure();
        test_valid_during_stream();
        test_reset_midstream();
        test_all_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
